// File: rtl/mem_loader_pkg.sv
// Shared definitions for the byte-stream memory loader: FSM states,
// stream framing constants and state-class decoders.
package mem_loader_pkg;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        LEN_HI  = 4'd1,
        LEN_LO  = 4'd2,
        WORD_HI = 4'd3,
        WORD_LO = 4'd4,
        WRITE   = 4'd5,
        CHK     = 4'd6,
        DONE    = 4'd7,
        ERR     = 4'd8
    } state_e;

    localparam int unsigned HdrLen   = 2;
    localparam int unsigned ChkWidth = 8;

    function automatic logic takes_byte(input state_e s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == WORD_HI) ||
               (s == WORD_LO) || (s == CHK);
    endfunction

    function automatic logic in_load(input state_e s);
        return takes_byte(s) || (s == WRITE);
    endfunction

endpackage

// File: rtl/mem_loader_xor_accum.sv
// Running XOR checksum over accepted stream bytes, cleared at load start.
module xor_accum
    import mem_loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                enable_i,
    input  logic [7:0]          byte_i,
    output logic [ChkWidth-1:0] sum_o
);

    logic [ChkWidth-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (clear_i) begin
            sum_q <= '0;
        end else if (enable_i) begin
            sum_q <= sum_q ^ byte_i;
        end else begin
            sum_q <= sum_q;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/mem_loader.sv
// Parses a length-prefixed, XOR-checksummed byte stream and writes the
// carried words to consecutive memory addresses starting at zero.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int AddrSize = 11,
    parameter int WordSize = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                WE,
    output logic [AddrSize-1:0] waddr,
    output logic [WordSize-1:0] DI,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int LenW = HdrLen * 8;

    state_e              state_q, state_d;
    logic                byte_ready_q, we_q, busy_q, done_q, err_q;
    logic [AddrSize-1:0] waddr_q;
    logic [WordSize-1:0] di_q;
    logic [7:0]          len_hi_q, hi_q;
    logic [LenW-1:0]     len_q, count_q;

    logic                fire_s, start_s, too_long_s, hi_bad_s, last_word_s;
    logic [LenW-1:0]     len_s;
    logic [ChkWidth-1:0] sum_s;

    assign fire_s      = byte_valid && byte_ready_q;
    assign start_s     = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));
    assign len_s       = {len_hi_q, byte_in};
    assign too_long_s  = 32'(len_s) > (32'd1 << AddrSize);
    // HI may only carry the bits of the word above the low byte.
    assign hi_bad_s    = (byte_in >> (WordSize - 8)) != 8'd0;
    assign last_word_s = (count_q + LenW'(1)) == len_q;

    xor_accum u_xor_accum (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (start_s),
        .enable_i (fire_s && (state_q != CHK)),
        .byte_i   (byte_in),
        .sum_o    (sum_s)
    );

    // Next-state decode of the stream parser.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_s) state_d = LEN_HI;
                else         state_d = state_q;
            end
            LEN_HI: begin
                if (fire_s) state_d = LEN_LO;
                else        state_d = state_q;
            end
            LEN_LO: begin
                if (!fire_s)                state_d = state_q;
                else if (too_long_s)        state_d = ERR;
                else if (len_s == LenW'(0)) state_d = CHK;
                else                        state_d = WORD_HI;
            end
            WORD_HI: begin
                if (!fire_s)      state_d = state_q;
                else if (hi_bad_s) state_d = ERR;
                else              state_d = WORD_LO;
            end
            WORD_LO: begin
                if (fire_s) state_d = WRITE;
                else        state_d = state_q;
            end
            WRITE: begin
                if (last_word_s) state_d = CHK;
                else             state_d = WORD_HI;
            end
            CHK: begin
                if (!fire_s)              state_d = state_q;
                else if (byte_in == sum_s) state_d = DONE;
                else                      state_d = ERR;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and registered outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            byte_ready_q <= 1'b0;
            we_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            waddr_q      <= '0;
            di_q         <= '0;
            len_hi_q     <= 8'd0;
            hi_q         <= 8'd0;
            len_q        <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= takes_byte(state_d);
            busy_q       <= in_load(state_d);
            we_q         <= (state_d == WRITE);
            done_q       <= (state_d == DONE);
            err_q        <= (state_d == ERR);
            // Saturate so a full-depth load never wraps back onto address 0.
            if (start_s) begin
                waddr_q <= '0;
                count_q <= '0;
            end else if (state_q == WRITE) begin
                count_q <= count_q + LenW'(1);
                if (waddr_q != '1) waddr_q <= waddr_q + AddrSize'(1);
            end
            if (fire_s && (state_q == LEN_HI))  len_hi_q <= byte_in;
            if (fire_s && (state_q == LEN_LO))  len_q    <= len_s;
            if (fire_s && (state_q == WORD_HI)) hi_q     <= byte_in;
            if (fire_s && (state_q == WORD_LO)) di_q     <= WordSize'({hi_q, byte_in});
        end
    end

    assign byte_ready = byte_ready_q;
    assign WE         = we_q;
    assign waddr      = waddr_q;
    assign DI         = di_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 SHALL have parameter AddrSize, default 11, memory address width in bits.
REQ-002 SHALL have parameter WordSize, default 9, memory word width in bits (legal range 9..16).
REQ-003 clk  input  1  sole clock, all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 byte_in  input  8  incoming stream byte.
REQ-007 byte_valid  input  1  byte_in holds a byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 WE  output  1  memory write strobe, one cycle per word.
REQ-010 waddr  output  AddrSize  memory write address.
REQ-011 DI  output  WordSize  memory write data.
REQ-012 busy  output  1  load in progress.
REQ-013 done  output  1  last load completed with good checksum.
REQ-014 err  output  1  last load aborted or checksum failed.

Function
REQ-015 SHALL use states IDLE, LEN_HI, LEN_LO, WORD_HI, WORD_LO, WRITE, CHK, DONE, ERR.
REQ-016 A byte SHALL be consumed only on a cycle with byte_valid && byte_ready; byte_ready SHALL be 1 only in LEN_HI, LEN_LO, WORD_HI, WORD_LO, CHK.
REQ-017 start in IDLE, DONE or ERR SHALL clear done, err, waddr, checksum and enter LEN_HI next cycle; start in any other state SHALL be ignored.
REQ-018 Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N pairs {HI, LO}, then one checksum byte.
REQ-019 After LEN_LO: N > 2^AddrSize -> ERR; N == 0 -> CHK; else -> WORD_HI.
REQ-020 Word value SHALL be {HI[WordSize-9:0], LO}; any HI bit above WordSize-9 set -> ERR after HI consumed.
REQ-021 WRITE SHALL last exactly one cycle with WE=1, waddr=current address, DI=assembled word; next state CHK if this was word N, else WORD_HI; waddr increments by 1 on exit.
REQ-022 WE SHALL be 0 in every state other than WRITE; DI SHALL hold its last value otherwise.
REQ-023 Checksum SHALL be 8-bit XOR of all bytes from LEN_HI through the last LO byte; CHK byte equal -> DONE, unequal -> ERR.
REQ-024 Address SHALL never wrap: N = 2^AddrSize writes addresses 0..2^AddrSize-1 exactly once.
REQ-025 busy SHALL be 1 in LEN_HI..CHK, 0 in IDLE, DONE, ERR.
REQ-026 done/err SHALL be 1 in DONE/ERR respectively and hold until next start or rst; never both 1.
REQ-027 Absent byte_valid the FSM SHALL wait indefinitely in a byte state (no timeout).

Reset
REQ-028 rst SHALL asynchronously force IDLE, WE=0, byte_ready=0, busy=0, done=0, err=0, waddr=0, DI=0, count=0, checksum=0.
REQ-029 rst asserted mid-load (including during WRITE) SHALL drop WE the same instant; no partial state survives.

Structure
REQ-030 State encoding and the stream-format constants (header length 2, checksum width 8) SHALL live in a shared loader package.
REQ-031 Checksum accumulator SHALL be a sub-module named xor_accum (clear, enable, byte in, 8-bit out); no other sub-modules.

Verification
REQ-032 N=3, words 0x001,0x1FF,0x0A5, correct checksum -> WE pulses at waddr 0,1,2 with those DI values, then done=1, err=0, busy=0.
REQ-033 N=0, checksum byte 0x00 -> no WE, done=1; checksum 0x01 -> err=1.
REQ-034 Same as REQ-032 with checksum byte corrupted -> three writes occur, then err=1, done=0.
REQ-035 Header N=0x0801 with AddrSize=11 -> err=1 after LEN_LO, zero WE pulses, byte_ready=0.
REQ-036 byte_valid toggled randomly, start pulsed while busy -> identical writes to REQ-032, start ignored.
REQ-037 rst asserted during second WRITE -> WE falls asynchronously, all outputs reset values; new start then full load succeeds from waddr 0.
